lsu_mem: RTL and testbench

LSU_MEM -- requirements
Module: lsu_mem

---
 rtl/lsu_mem.sv | 156 +++++++++++++++
 tb/tb_lsu_mem.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem.sv
// Load/store unit for the MEM stage: non-memory ops pass straight through,
// loads and stores go out on a simple req/gnt + rvalid bus.
module lsu_mem (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_i,
    input  logic        mem_read_i,
    input  logic        mem_write_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] alu_out_i,
    input  logic [31:0] rdata2_i,
    input  logic [31:0] pc_incr_i,
    output logic        stall_o,
    output logic        valid_o,
    output logic        err_o,
    output logic [31:0] rdata_o,
    output logic [31:0] alu_out_o,
    output logic [31:0] pc_incr_o,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [31:0] bus_wdata_o,
    output logic [3:0]  bus_be_o,
    input  logic        bus_gnt_i,
    input  logic        bus_rvalid_i,
    input  logic [31:0] bus_rdata_i
);

    typedef enum logic [1:0] {StIdle, StReq, StWait, StResp} state_e;

    state_e      r_state, w_state_next;
    logic        r_valid, r_err, r_we;
    logic [2:0]  r_funct3;
    logic [3:0]  r_be;
    logic [31:0] r_addr, r_wdata, r_rdata, r_alu_out, r_pc_incr;

    logic        w_is_mem, w_bad_f3, w_misal, w_err, w_idle_take, w_mem_take;
    logic [3:0]  w_be;
    logic [31:0] w_wdata, w_load_data;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Request decode and store formatting, evaluated only in the IDLE accept cycle.
    always_comb begin
        w_is_mem = mem_read_i ^ mem_write_i;
        if (mem_write_i) begin
            w_bad_f3 = funct3_i[2] | (funct3_i[1:0] == 2'b11);
        end else begin
            w_bad_f3 = (funct3_i[1:0] == 2'b11) | (funct3_i == 3'b110);
        end
        w_misal = ((funct3_i[1:0] == 2'b01) & alu_out_i[0]) |
                  ((funct3_i[1:0] == 2'b10) & (alu_out_i[1:0] != 2'b00));
        w_err = (mem_read_i & mem_write_i) | (w_is_mem & (w_bad_f3 | w_misal));
        w_idle_take = (r_state == StIdle) & valid_i & ~rst;
        w_mem_take  = w_idle_take & w_is_mem & ~w_err;
        case (funct3_i[1:0])
            2'b00: begin
                w_be    = 4'b0001 << alu_out_i[1:0];
                w_wdata = {4{rdata2_i[7:0]}};
            end
            2'b01: begin
                w_be    = 4'b0011 << {alu_out_i[1], 1'b0};
                w_wdata = {2{rdata2_i[15:0]}};
            end
            default: begin
                w_be    = 4'b1111;
                w_wdata = rdata2_i;
            end
        endcase
    end

    always_comb begin
        case (r_addr[1:0])
            2'b00:   w_byte = bus_rdata_i[7:0];
            2'b01:   w_byte = bus_rdata_i[15:8];
            2'b10:   w_byte = bus_rdata_i[23:16];
            default: w_byte = bus_rdata_i[31:24];
        endcase
        w_half = r_addr[1] ? bus_rdata_i[31:16] : bus_rdata_i[15:0];
        case (r_funct3)
            3'b000:  w_load_data = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_load_data = {{16{w_half[15]}}, w_half};
            3'b100:  w_load_data = {24'b0, w_byte};
            3'b101:  w_load_data = {16'b0, w_half};
            default: w_load_data = bus_rdata_i;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= StIdle;
            r_valid   <= 1'b0;
            r_err     <= 1'b0;
            r_we      <= 1'b0;
            r_funct3  <= 3'b0;
            r_be      <= 4'b0;
            r_addr    <= 32'b0;
            r_wdata   <= 32'b0;
            r_rdata   <= 32'b0;
            r_alu_out <= 32'b0;
            r_pc_incr <= 32'b0;
        end else begin
            r_state <= w_state_next;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
            if (w_idle_take) begin
                r_alu_out <= alu_out_i;
                r_pc_incr <= pc_incr_i;
                r_rdata   <= 32'b0;
                // Non-memory ops and rejected accesses complete next cycle.
                r_valid   <= ~w_mem_take;
                r_err     <= w_err;
            end
            if (w_mem_take) begin
                r_addr   <= alu_out_i;
                r_we     <= mem_write_i;
                r_funct3 <= funct3_i;
                r_be     <= w_be;
                r_wdata  <= w_wdata;
            end
            if ((r_state == StWait) && bus_rvalid_i) begin
                r_rdata <= w_load_data;
            end
            if ((r_state != StResp) && (w_state_next == StResp)) begin
                r_valid <= 1'b1;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle: if (w_mem_take) w_state_next = StReq;
            StReq:  if (bus_gnt_i) w_state_next = r_we ? StResp : StWait;
            StWait: if (bus_rvalid_i) w_state_next = StResp;
            StResp: w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
        if (rst) w_state_next = StIdle;
    end

    always_comb begin
        bus_req_o   = (r_state == StReq);
        bus_we_o    = bus_req_o & r_we;
        bus_addr_o  = bus_req_o ? {r_addr[31:2], 2'b00} : 32'b0;
        bus_be_o    = bus_req_o ? r_be : 4'b0;
        bus_wdata_o = bus_req_o ? r_wdata : 32'b0;
        stall_o     = (r_state == StReq) | (r_state == StWait) | w_mem_take;
        valid_o     = r_valid;
        err_o       = r_err;
        rdata_o     = r_rdata;
        alu_out_o   = r_alu_out;
        pc_incr_o   = r_pc_incr;
    end

endmodule

// File: tb/tb_lsu_mem.sv
// Bench for lsu_mem: table-driven ops with a bus responder and a result scoreboard.
module tb_lsu_mem;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_i, mem_read_i, mem_write_i;
    logic [2:0]  funct3_i;
    logic [31:0] alu_out_i, rdata2_i, pc_incr_i;
    logic        stall_o, valid_o, err_o;
    logic [31:0] rdata_o, alu_out_o, pc_incr_o;
    logic        bus_req_o, bus_we_o;
    logic [31:0] bus_addr_o, bus_wdata_o;
    logic [3:0]  bus_be_o;
    logic        bus_gnt_i, bus_rvalid_i;
    logic [31:0] bus_rdata_i;

    lsu_mem dut (
        .clk          (clk),
        .rst          (rst),
        .valid_i      (valid_i),
        .mem_read_i   (mem_read_i),
        .mem_write_i  (mem_write_i),
        .funct3_i     (funct3_i),
        .alu_out_i    (alu_out_i),
        .rdata2_i     (rdata2_i),
        .pc_incr_i    (pc_incr_i),
        .stall_o      (stall_o),
        .valid_o      (valid_o),
        .err_o        (err_o),
        .rdata_o      (rdata_o),
        .alu_out_o    (alu_out_o),
        .pc_incr_o    (pc_incr_o),
        .bus_req_o    (bus_req_o),
        .bus_we_o     (bus_we_o),
        .bus_addr_o   (bus_addr_o),
        .bus_wdata_o  (bus_wdata_o),
        .bus_be_o     (bus_be_o),
        .bus_gnt_i    (bus_gnt_i),
        .bus_rvalid_i (bus_rvalid_i),
        .bus_rdata_i  (bus_rdata_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] data;
        int          gd;
        int          rdl;
        logic [31:0] word;
    } op_t;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        logic [31:0] alu;
        logic [31:0] pc;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    op_t  ops[15];
    int   n_vec = 0;
    int   n_err = 0;
    int   n_pulse = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic model_err(logic rd, logic wr, logic [2:0] f3, logic [31:0] a);
        int sz;
        if (rd && wr) return 1'b1;
        if (!rd && !wr) return 1'b0;
        if (wr && f3 > 3'd2) return 1'b1;
        if (rd && (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7)) return 1'b1;
        sz = 1 << f3[1:0];
        return (int'(a[1:0]) % sz) != 0;
    endfunction

    function automatic logic [31:0] model_load(logic [2:0] f3, logic [31:0] a, logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[8*int'(a[1:0]) +: 8];
        h = a[1] ? w[31:16] : w[15:0];
        case (f3)
            3'd0:    return {{24{b[7]}}, b};
            3'd1:    return {{16{h[15]}}, h};
            3'd4:    return {24'b0, b};
            3'd5:    return {16'b0, h};
            default: return w;
        endcase
    endfunction

    function automatic logic [3:0] model_be(logic [2:0] f3, logic [31:0] a);
        logic [3:0] be;
        int sz, base;
        sz   = 1 << f3[1:0];
        base = int'(a[1:0]) & ~(sz - 1);
        for (int i = 0; i < 4; i++) be[i] = (i >= base) && (i < base + sz);
        return be;
    endfunction

    function automatic logic [31:0] model_wdata(logic [2:0] f3, logic [31:0] d);
        logic [31:0] r;
        int sz;
        sz = 1 << f3[1:0];
        for (int i = 0; i < 4; i++) r[8*i +: 8] = d[8*(i % sz) +: 8];
        return r;
    endfunction

    always @(negedge clk) begin
        if (!rst && valid_o) begin
            n_pulse++;
            if (sb_q.size() == 0) begin
                check_eq("unexpected_valid", {31'b0, valid_o}, 32'd0);
            end else begin
                mon_e = sb_q.pop_front();
                check_eq("err", {31'b0, err_o}, {31'b0, mon_e.err});
                check_eq("rdata", rdata_o, mon_e.rdata);
                check_eq("alu_out", alu_out_o, mon_e.alu);
                check_eq("pc_incr", pc_incr_o, mon_e.pc);
            end
        end
    end

    task automatic run_op(input op_t op, input int idx);
        logic [31:0] pc;
        logic        e_err, mem_ok, stall_prev, done;
        int          lat, k, req_cnt, rv_at;
        pc     = 32'h1000 + 32'(idx * 4);
        e_err  = model_err(op.rd, op.wr, op.f3, op.addr);
        mem_ok = (op.rd ^ op.wr) && !e_err;
        lat    = !mem_ok ? 1 : (op.wr ? 2 + op.gd : 3 + op.gd + op.rdl);
        @(posedge clk); #1;
        valid_i      = 1'b1;
        mem_read_i   = op.rd;
        mem_write_i  = op.wr;
        funct3_i     = op.f3;
        alu_out_i    = op.addr;
        rdata2_i     = op.data;
        pc_incr_i    = pc;
        bus_gnt_i    = 1'b0;
        bus_rvalid_i = 1'b0;
        bus_rdata_i  = op.word;
        sb_q.push_back('{e_err, (mem_ok && op.rd) ? model_load(op.f3, op.addr, op.word) : 32'd0,
                         op.addr, pc});
        @(negedge clk);
        check_eq("stall_accept", {31'b0, stall_o}, {31'b0, mem_ok});
        stall_prev = stall_o;
        k = 0; req_cnt = 0; rv_at = -1; done = 1'b0;
        while (!done && k < 30) begin
            @(posedge clk); #1;
            k++;
            if (!stall_prev) valid_i = 1'b0;
            bus_gnt_i = bus_req_o && (req_cnt == op.gd);
            if (bus_gnt_i && op.rd) rv_at = k + 1 + op.rdl;
            bus_rvalid_i = (k == rv_at);
            @(negedge clk);
            if (bus_req_o) begin
                req_cnt++;
                check_eq("bus_addr", bus_addr_o, {op.addr[31:2], 2'b00});
                check_eq("bus_we", {31'b0, bus_we_o}, {31'b0, op.wr});
                if (op.wr) begin
                    check_eq("bus_be", {28'b0, bus_be_o}, {28'b0, model_be(op.f3, op.addr)});
                    check_eq("bus_wdata", bus_wdata_o, model_wdata(op.f3, op.data));
                end
            end else begin
                check_eq("idle_be", {28'b0, bus_be_o}, 32'd0);
                check_eq("idle_wdata", bus_wdata_o, 32'd0);
            end
            if (!mem_ok) begin
                check_eq("no_stall", {31'b0, stall_o}, 32'd0);
                check_eq("no_req", {31'b0, bus_req_o}, 32'd0);
            end
            stall_prev = stall_o;
            if (valid_o) begin
                check_eq("latency", k, lat);
                done = 1'b1;
            end
        end
        if (!done) check_eq("timeout", k, lat);
        if (mem_ok) check_eq("req_cycles", req_cnt, op.gd + 1);
        bus_gnt_i    = 1'b0;
        bus_rvalid_i = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            valid_i      = 1'b0;
            bus_gnt_i    = 1'b0;
            bus_rvalid_i = 1'b0;
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_stall"}, {31'b0, stall_o}, 32'd0);
        check_eq({tag, "_valid"}, {31'b0, valid_o}, 32'd0);
        check_eq({tag, "_err"}, {31'b0, err_o}, 32'd0);
        check_eq({tag, "_breq"}, {31'b0, bus_req_o}, 32'd0);
        check_eq({tag, "_rdata"}, rdata_o, 32'd0);
        check_eq({tag, "_alu"}, alu_out_o, 32'd0);
        check_eq({tag, "_pc"}, pc_incr_o, 32'd0);
    endtask

    // Starts a load, lets it reach REQ (hold_gnt=0) or WAIT (gnt once), then resets.
    task automatic reset_mid_load(input logic to_wait);
        @(posedge clk); #1;
        valid_i = 1'b1; mem_read_i = 1'b1; mem_write_i = 1'b0; funct3_i = 3'd2;
        alu_out_i = 32'h200; rdata2_i = 32'd0; pc_incr_i = 32'h2000;
        bus_rdata_i = 32'h5555_AAAA; bus_gnt_i = 1'b0; bus_rvalid_i = 1'b0;
        @(posedge clk); #1;
        bus_gnt_i = to_wait;
        @(negedge clk);
        check_eq("pre_rst_req", {31'b0, bus_req_o}, 32'd1);
        @(posedge clk); #1;
        bus_gnt_i = 1'b0;
        rst = 1'b1;
        valid_i = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_all_zero("post_rst");
        @(posedge clk); #1;
        bus_rvalid_i = 1'b1;
        @(negedge clk);
        check_eq("late_rvalid_valid", {31'b0, valid_o}, 32'd0);
        @(posedge clk); #1;
        bus_rvalid_i = 1'b0;
        @(negedge clk);
        check_eq("late_rvalid_valid2", {31'b0, valid_o}, 32'd0);
        check_eq("late_rvalid_req", {31'b0, bus_req_o}, 32'd0);
        check_eq("late_rvalid_stall", {31'b0, stall_o}, 32'd0);
    endtask

    initial begin
        int p0;
        rst = 1'b1;
        valid_i = 1'b0; mem_read_i = 1'b0; mem_write_i = 1'b0; funct3_i = 3'd0;
        alu_out_i = 32'd0; rdata2_i = 32'd0; pc_incr_i = 32'd0;
        bus_gnt_i = 1'b0; bus_rvalid_i = 1'b0; bus_rdata_i = 32'd0;

        ops[0]  = '{1'b0, 1'b0, 3'd0, 32'h0000_1234, 32'd0,         0, 0, 32'd0};
        ops[1]  = '{1'b0, 1'b1, 3'd0, 32'h0000_0103, 32'h0000_00AB, 2, 0, 32'd0};
        ops[2]  = '{1'b1, 1'b0, 3'd1, 32'h0000_0102, 32'd0,         0, 0, 32'h8001_0000};
        ops[3]  = '{1'b1, 1'b0, 3'd5, 32'h0000_0102, 32'd0,         0, 0, 32'h8001_0000};
        ops[4]  = '{1'b1, 1'b0, 3'd2, 32'h0000_0101, 32'd0,         0, 0, 32'd0};
        ops[5]  = '{1'b0, 1'b1, 3'd1, 32'h0000_0102, 32'h1234_BEEF, 1, 0, 32'd0};
        ops[6]  = '{1'b1, 1'b0, 3'd0, 32'h0000_0101, 32'd0,         1, 2, 32'h1234_80FF};
        ops[7]  = '{1'b1, 1'b0, 3'd4, 32'h0000_0103, 32'd0,         0, 0, 32'hAB00_0000};
        ops[8]  = '{1'b1, 1'b0, 3'd2, 32'h0000_0104, 32'd0,         0, 2, 32'hDEAD_BEEF};
        ops[9]  = '{1'b1, 1'b0, 3'd3, 32'h0000_0100, 32'd0,         0, 0, 32'd0};
        ops[10] = '{1'b0, 1'b1, 3'd4, 32'h0000_0100, 32'h1111_2222, 0, 0, 32'd0};
        ops[11] = '{1'b1, 1'b1, 3'd2, 32'h0000_0100, 32'd0,         0, 0, 32'd0};
        ops[12] = '{1'b0, 1'b1, 3'd1, 32'h0000_0101, 32'h3333_4444, 0, 0, 32'd0};
        ops[13] = '{1'b0, 1'b1, 3'd2, 32'h0000_0108, 32'hCAFE_F00D, 0, 0, 32'd0};
        ops[14] = '{1'b0, 1'b0, 3'd0, 32'hFFFF_0000, 32'd0,         0, 0, 32'd0};

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_all_zero("reset");

        for (int i = 0; i < 13; i++) run_op(ops[i], i);
        idle_cycles(2);

        p0 = n_pulse;
        run_op(ops[13], 13);
        run_op(ops[14], 14);
        idle_cycles(3);
        check_eq("b2b_pulses", n_pulse - p0, 2);

        reset_mid_load(1'b1);
        reset_mid_load(1'b0);
        run_op(ops[0], 20);
        idle_cycles(3);

        check_eq("sb_drained", sb_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
